pipe_ifu: RTL and testbench
===========================

# pipe_ifu

Instruction-fetch stage of the `pipe_*` pipeline and the producer side of the IF→ID valid/ready handshake. It owns the PC and issues one fetch at a time to instruction memory. Responses go into a 2-entry output queue so `pipe_idu` backpressure does not stall the next fetch. `flush_i` redirects the PC and discards all in-flight and queued fetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: PC fetched first after reset.

Ports:
- `clk_i` in 1: clock. All state changes on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: redirect request, sampled at the clock edge.
- `redirect_pc_i` in 32: new fetch PC, valid while `flush_i`=1.
- `imem_req_valid_o` out 1: fetch request valid.
- `imem_req_ready_i` in 1: memory accepts the request.
- `imem_req_addr_o` out 32: fetch address, equal to the current PC.
- `imem_rsp_valid_i` in 1: response valid for the single outstanding request. Responses have no backpressure.
- `imem_rsp_data_i` in 32: fetched instruction.
- `if_valid_o` out 1: `ifToId_o` holds a valid entry.
- `id_ready_i` in 1: ID accepts the entry this cycle.
- `ifToId_o` out `ifToId_t` (liang_pkg, fields `pc`, `inst`): head entry of the queue.

## Operation
- State machine, 2 bits:
  - S_REQ: may issue a request.
  - S_WAIT: one request outstanding.
  - S_DROP: one stale request outstanding; its response is discarded.
- Request rule: `imem_req_valid_o` = (state==S_REQ) && (q_count<2). It is registered-state logic only; no combinational path from `flush_i`.
- Request handshake (`req_fire`) = `imem_req_valid_o` && `imem_req_ready_i`. On `req_fire`:
  - `req_pc` <= PC.
  - PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - S_REQ → S_WAIT.
- Response in S_WAIT: push {pc=`req_pc`, inst=`imem_rsp_data_i`} at the queue tail, then go to S_REQ.
- Response in S_DROP: discard the data, then go to S_REQ.
- `imem_rsp_valid_i` in S_REQ is a protocol error and is ignored.
- Queue:
  - 2-entry circular buffer with 1-bit read/write pointers and a 2-bit `q_count`.
  - Pop when `if_valid_o` && `id_ready_i`.
  - Push and pop may occur in the same cycle; `q_count` is then unchanged.
  - Overflow cannot occur: a request is issued only when `q_count`<2, and `q_count` never grows before that request's response.
- Flush (`flush_i`=1) has priority over every other event in that cycle:
  - PC <= `redirect_pc_i`.
  - Queue cleared: `q_count`=0, both pointers 0. Any same-cycle pop or push is void.
  - S_WAIT with no response this cycle → S_DROP.
  - S_WAIT with a response this cycle → S_REQ, and the data is discarded.
  - S_REQ with `req_fire` this cycle → S_DROP. The request just accepted is stale and PC does not take +4.
  - S_REQ without `req_fire` → S_REQ.
  - S_DROP with no response → S_DROP. The new PC is kept.
  - S_DROP with a response → S_REQ.
- The first request after a flush uses `redirect_pc_i` exactly.

## Timing
- Reset values:
  - PC=`RESET_PC`, `req_pc`=0, state=S_REQ, `q_count`=0.
  - `imem_req_valid_o`=1 with `imem_req_addr_o`=`RESET_PC` once reset is released.
  - `if_valid_o`=0 and `ifToId_o`='0 while in reset.
- Reset asserted mid-operation returns to the reset values immediately. Any outstanding memory response after reset release is not tracked; the memory side is reset together with this block.
- Latency:
  - Response in cycle N → `if_valid_o`=1 in cycle N+1, if the queue was empty.
  - With zero-latency memory (response one cycle after `req_fire`), sustained throughput is one instruction per 2 cycles.
- `ifToId_o` and `if_valid_o` are driven only from registered state. They stay stable while `if_valid_o`=1 and `id_ready_i`=0.
- `flush_i` in cycle N → first redirected request in cycle N+1 (from S_REQ/S_WAIT-with-response) or after the stale response arrives (from S_DROP). `if_valid_o`=0 in cycle N+1.

## Test plan
- **Reset and first fetch.** Release reset; memory ready=1 and responds 1 cycle after each request with inst=32'h0000_0013. Required:
  - Request addresses 8000_0000, 8000_0004, 8000_0008.
  - `ifToId_o.pc` values match those addresses in order.
  - `if_valid_o` first rises 2 cycles after the first `req_fire`.
- **ID backpressure.** Hold `id_ready_i`=0 for 10 cycles. Required:
  - Exactly 2 entries are queued: pc 8000_0000 and 8000_0004.
  - `imem_req_valid_o`=0 from then on.
  - `ifToId_o` is stable throughout.
  - Raising `id_ready_i` drains the entries in order and fetching resumes at 8000_0008.
- **Flush while waiting.** Flush with redirect 8000_0100 while a request to 8000_0008 is outstanding; the response arrives 3 cycles later. Required:
  - The response is discarded.
  - The next request is to 8000_0100.
  - No entry with pc 8000_0008 ever reaches ID.
- **Flush with simultaneous response, and flush with simultaneous `req_fire`.** Required:
  - Neither stale instruction reaches ID.
  - The first post-flush address is `redirect_pc_i`.
- **Wrap-around and mid-run reset.** Flush to FFFF_FFFC and let two requests issue. Required:
  - Addresses FFFF_FFFC, then 0000_0000.
  - Asserting `rst_i` asynchronously mid-wait forces `if_valid_o`=0 and PC=`RESET_PC` without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ifu.sv
// Instruction fetch: one outstanding imem request, responses land in a 2-entry queue toward ID.
// Response in cycle N is visible to ID in N+1; ID backpressure only stops new fetches once the queue is full.
package liang_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifToId_t;
endpackage

module pipe_ifu
    import liang_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        if_valid_o,
    input  logic        id_ready_i,
    output ifToId_t     ifToId_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    ifToId_t     r_q [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_q_count;

    logic        w_req_fire;
    logic        w_push;
    logic        w_pop;

    assign imem_req_valid_o = (r_state == S_REQ) && (r_q_count < 2'd2);
    assign imem_req_addr_o  = r_pc;
    assign if_valid_o       = (r_q_count != 2'd0);
    assign ifToId_o         = r_q[r_rptr];

    assign w_req_fire = imem_req_valid_o && imem_req_ready_i;
    assign w_push     = (r_state == S_WAIT) && imem_rsp_valid_i;
    assign w_pop      = if_valid_o && id_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_req_pc  <= '0;
            r_q[0]    <= '0;
            r_q[1]    <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_q_count <= 2'd0;
        end else if (flush_i) begin
            // Anything in flight becomes stale; an outstanding response without arrival moves us to S_DROP.
            r_pc      <= redirect_pc_i;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_q_count <= 2'd0;
            case (r_state)
                S_REQ:   r_state <= w_req_fire ? S_DROP : S_REQ;
                S_WAIT,
                S_DROP:  r_state <= imem_rsp_valid_i ? S_REQ : S_DROP;
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_req_fire) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (imem_rsp_valid_i) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase

            if (w_push) begin
                r_q[r_wptr] <= '{pc: r_req_pc, inst: imem_rsp_data_i};
                r_wptr      <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_q_count <= r_q_count + 2'd1;
                2'b01:   r_q_count <= r_q_count - 2'd1;
                default: r_q_count <= r_q_count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ifu.sv
// Bench for pipe_ifu: directed scenarios plus a random run against a queue-level fetch model.
module tb_pipe_ifu;
    import liang_pkg::*;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        if_valid_o;
    logic        id_ready_i = 1'b0;
    ifToId_t     ifToId_o;

    pipe_ifu #(.RESET_PC(RPC)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .if_valid_o       (if_valid_o),
        .id_ready_i       (id_ready_i),
        .ifToId_o         (ifToId_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: expected next fetch address, one outstanding request, FIFO of deliverable entries.
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_out;
    bit          m_stale;
    ifToId_t     m_q[$];

    bit          mem_pend;
    int          mem_wait;
    logic [31:0] mem_addr;

    int          k_ready;
    int          k_idr;
    int          k_lat_lo;
    int          k_lat_hi;
    bit          k_const;
    int          k_flush_pct;

    logic [31:0] addr_log[$];
    logic [31:0] pop_log[$];
    int          cyc;
    int          first_fire;
    int          first_vld;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return k_const ? 32'h0000_0013 : (a ^ 32'h5A5A_0013);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_pc = RPC;
        m_req_pc = '0;
        m_out = 0;
        m_stale = 0;
        m_q.delete();
        mem_pend = 0;
        mem_wait = 0;
        mem_addr = '0;
        addr_log.delete();
        pop_log.delete();
        cyc = 0;
        first_fire = -1;
        first_vld = -1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        flush_i = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        id_ready_i = 1'b0;
        @(negedge clk_i);
        chk("rst_if_valid", 64'(if_valid_o), 64'(0));
        chk("rst_head", 64'(ifToId_o), 64'(0));
        rst_i = 1'b0;
        reset_model();
    endtask

    // One clock: check outputs, drive inputs, advance the model across the coming edge.
    task automatic cycle(input logic fl, input logic [31:0] rd);
        bit          exp_rv;
        bit          ready;
        bit          idr;
        bit          rsp;
        bit          fire;
        bit          dut_fire;
        logic        f;
        logic [31:0] r;

        exp_rv = !m_out && (m_q.size() < 2);
        chk("req_valid", 64'(imem_req_valid_o), 64'(exp_rv));
        if (exp_rv) chk("req_addr", 64'(imem_req_addr_o), 64'(m_pc));
        chk("if_valid", 64'(if_valid_o), 64'(m_q.size() != 0));
        if (m_q.size() != 0) chk("if_head", 64'(ifToId_o), 64'(m_q[0]));

        f = fl;
        r = rd;
        if (!fl && k_flush_pct > 0 && int'($urandom_range(0, 99)) < k_flush_pct) begin
            f = 1'b1;
            r = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        end
        ready = (k_ready == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
        idr   = (k_idr == 1) ? 1'b1 : (k_idr == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
        rsp   = mem_pend && (mem_wait == 0);

        flush_i          = f;
        redirect_pc_i    = r;
        imem_req_ready_i = ready;
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = rsp ? inst_of(mem_addr) : 32'hDEAD_BEEF;
        id_ready_i       = idr;

        dut_fire = imem_req_valid_o && ready;
        if (dut_fire) addr_log.push_back(imem_req_addr_o);
        if (dut_fire && first_fire < 0) first_fire = cyc;
        if (if_valid_o && first_vld < 0) first_vld = cyc;
        if (if_valid_o && idr && !f) pop_log.push_back(ifToId_o.pc);

        if (rsp) mem_pend = 0;
        else if (mem_pend) mem_wait--;
        if (dut_fire) begin
            mem_pend = 1;
            mem_addr = imem_req_addr_o;
            mem_wait = int'($urandom_range(k_lat_lo, k_lat_hi)) - 1;
        end

        fire = exp_rv && ready;
        if (f) begin
            m_q.delete();
            m_pc = r;
            if (fire) begin
                m_out = 1;
                m_stale = 1;
            end else if (m_out && rsp) begin
                m_out = 0;
            end else if (m_out) begin
                m_stale = 1;
            end
        end else begin
            if (idr && m_q.size() != 0) void'(m_q.pop_front());
            if (m_out && rsp) begin
                if (!m_stale) m_q.push_back('{pc: m_req_pc, inst: inst_of(m_req_pc)});
                m_out = 0;
            end
            if (fire) begin
                m_out = 1;
                m_stale = 0;
                m_req_pc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk_i);
    endtask

    function automatic int count_pops(input logic [31:0] pc);
        int n = 0;
        foreach (pop_log[i]) if (pop_log[i] == pc) n++;
        return n;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  fidx;
        bit  found;

        // Reset and first fetch with single-cycle memory.
        k_ready = 1; k_idr = 1; k_lat_lo = 1; k_lat_hi = 1; k_const = 1; k_flush_pct = 0;
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, '0);
        chk("A_addr0", 64'(addr_log[0]), 64'(32'h8000_0000));
        chk("A_addr1", 64'(addr_log[1]), 64'(32'h8000_0004));
        chk("A_addr2", 64'(addr_log[2]), 64'(32'h8000_0008));
        chk("A_pop0", 64'(pop_log[0]), 64'(32'h8000_0000));
        chk("A_pop1", 64'(pop_log[1]), 64'(32'h8000_0004));
        chk("A_pop2", 64'(pop_log[2]), 64'(32'h8000_0008));
        chk("A_latency", 64'(first_vld - first_fire), 64'(2));

        // ID backpressure: queue fills to two, fetch stalls, then drains in order.
        k_idr = 2; k_const = 0;
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, '0);
        chk("B_nreq", 64'(addr_log.size()), 64'(2));
        chk("B_valid", 64'(if_valid_o), 64'(1));
        chk("B_head_pc", 64'(ifToId_o.pc), 64'(32'h8000_0000));
        k_idr = 1;
        for (int i = 0; i < 12; i++) cycle(1'b0, '0);
        chk("B_pop0", 64'(pop_log[0]), 64'(32'h8000_0000));
        chk("B_pop1", 64'(pop_log[1]), 64'(32'h8000_0004));
        chk("B_resume", 64'(addr_log[2]), 64'(32'h8000_0008));

        // Flush while a request is outstanding; its response lands three cycles later.
        k_lat_lo = 4; k_lat_hi = 4;
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, '0);
            found = m_out && mem_addr == 32'h8000_0008 && mem_wait == 3;
        end
        chk("C_reach", 64'(found), 64'(1));
        cycle(1'b1, 32'h8000_0100);
        fidx = addr_log.size();
        for (int i = 0; i < 16; i++) cycle(1'b0, '0);
        chk("C_have_req", 64'(addr_log.size() > fidx), 64'(1));
        if (addr_log.size() > fidx) chk("C_redirect", 64'(addr_log[fidx]), 64'(32'h8000_0100));
        chk("C_no_stale", 64'(count_pops(32'h8000_0008)), 64'(0));

        // Flush in the same cycle as a response, then in the same cycle as req_fire.
        k_lat_lo = 2; k_lat_hi = 2;
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, '0);
            found = mem_pend && mem_wait == 0 && mem_addr == 32'h8000_0004;
        end
        chk("D1_reach", 64'(found), 64'(1));
        cycle(1'b1, 32'h8000_0200);
        fidx = addr_log.size();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, '0);
            found = !m_out && m_q.size() < 2 && m_pc == 32'h8000_0204;
        end
        chk("D2_reach", 64'(found), 64'(1));
        chk("D1_redirect", 64'(addr_log[fidx]), 64'(32'h8000_0200));
        cycle(1'b1, 32'h8000_0300);
        fidx = addr_log.size();
        chk("D2_stale_fire", 64'(addr_log[fidx - 1]), 64'(32'h8000_0204));
        for (int i = 0; i < 16; i++) cycle(1'b0, '0);
        chk("D2_redirect", 64'(addr_log[fidx]), 64'(32'h8000_0300));
        chk("D1_no_stale", 64'(count_pops(32'h8000_0004)), 64'(0));
        chk("D2_no_stale", 64'(count_pops(32'h8000_0204)), 64'(0));

        // Wrap-around, then asynchronous reset while a request is outstanding.
        k_idr = 2; k_lat_lo = 3; k_lat_hi = 3;
        do_reset();
        cycle(1'b1, 32'hFFFF_FFFC);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle(1'b0, '0);
            found = m_out && m_q.size() == 1;
        end
        chk("E_reach", 64'(found), 64'(1));
        chk("E_nreq", 64'(addr_log.size()), 64'(3));
        chk("E_addr_top", 64'(addr_log[1]), 64'(32'hFFFF_FFFC));
        chk("E_addr_wrap", 64'(addr_log[2]), 64'(32'h0000_0000));
        chk("E_pre_valid", 64'(if_valid_o), 64'(1));
        #2;
        rst_i = 1'b1;
        #1;
        chk("E_async_valid", 64'(if_valid_o), 64'(0));
        chk("E_async_pc", 64'(imem_req_addr_o), 64'(RPC));
        chk("E_async_head", 64'(ifToId_o), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        reset_model();

        // Random traffic with random latency, backpressure and flushes.
        k_ready = 0; k_idr = 0; k_lat_lo = 1; k_lat_hi = 3; k_flush_pct = 6;
        do_reset();
        for (int i = 0; i < 800; i++) cycle(1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
